// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: round-robin arbiter sharing the single DDR command path
// between instruction read, data read, jump-address read and data store.
// One grant at a time; waits for the burst finish (or watchdog), then
// holds a short cooldown so the DDR interface can return to START.
module ddr_req_arbiter #(
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int LEN_WIDTH       = 8,
  parameter int COOLDOWN_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                      mem_clk,
  input  logic                      rst_n,
  input  logic                      ddr_init_input_finish,
  input  logic                      ic_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ic_addr,
  input  logic [LEN_WIDTH-1:0]      ic_len,
  input  logic                      dc_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0] dc_rd_addr,
  input  logic                      jmp_req,
  input  logic [DDR_ADDR_WIDTH-1:0] jmp_addr,
  input  logic                      st_req,
  input  logic [DDR_ADDR_WIDTH-1:0] st_addr,
  output logic [3:0]                grant_ack,
  output logic [3:0]                done,
  output logic                      err_timeout,
  output logic                      ins_read_req,
  output logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
  output logic [LEN_WIDTH-1:0]      ins_read_len,
  output logic                      data_read_req,
  output logic                      jmp_addr_read_req,
  output logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
  output logic                      data_store_req,
  output logic [DDR_ADDR_WIDTH-1:0] data_write_addr,
  input  logic                      rd_burst_finish,
  input  logic                      wr_burst_finish,
  output logic                      busy
);

  localparam logic [2:0] S_INIT_WAIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_COOLDOWN  = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

  logic [2:0]                r_state;
  logic [1:0]                r_rr_ptr;
  logic [TW-1:0]             r_wdog;
  logic [CW-1:0]             r_cd;
  logic [3:0]                r_grant;
  logic [3:0]                r_done;
  logic                      r_err;
  logic                      r_busy;
  logic                      r_ins_req;
  logic                      r_data_req;
  logic                      r_jmp_req;
  logic                      r_st_req;
  logic [DDR_ADDR_WIDTH-1:0] r_ins_addr;
  logic [LEN_WIDTH-1:0]      r_ins_len;
  logic [DDR_ADDR_WIDTH-1:0] r_rd_addr;
  logic [DDR_ADDR_WIDTH-1:0] r_wr_addr;

  logic [3:0] w_req;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_finish;

  // Round-robin search starting just after the last winner; first hit wins.
  always_comb begin
    w_req   = {st_req, jmp_req, dc_rd_req, ic_req};
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Stores complete on the write finish, all three read types on the read finish.
  assign w_finish = (r_rr_ptr == 2'd3) ? wr_burst_finish : rd_burst_finish;

  // Main arbitration FSM with registered pulses, request levels and latched addresses.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT_WAIT;
      r_rr_ptr   <= 2'd3;
      r_wdog     <= '0;
      r_cd       <= '0;
      r_grant    <= 4'b0000;
      r_done     <= 4'b0000;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_ins_req  <= 1'b0;
      r_data_req <= 1'b0;
      r_jmp_req  <= 1'b0;
      r_st_req   <= 1'b0;
      r_ins_addr <= '0;
      r_ins_len  <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
    end else begin
      r_grant <= 4'b0000;
      r_done  <= 4'b0000;
      r_err   <= 1'b0;
      r_busy  <= 1'b1;
      case (r_state)
        S_INIT_WAIT: begin
          if (ddr_init_input_finish) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_found) begin
            r_rr_ptr <= w_win;
            r_grant  <= 4'b0001 << w_win;
            r_state  <= S_ISSUE;
            case (w_win)
              2'd0: begin
                r_ins_addr <= ic_addr;
                r_ins_len  <= ic_len;
              end
              2'd1:    r_rd_addr <= dc_rd_addr;
              2'd2:    r_rd_addr <= jmp_addr;
              default: r_wr_addr <= st_addr;
            endcase
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          case (r_rr_ptr)
            2'd0:    r_ins_req  <= 1'b1;
            2'd1:    r_data_req <= 1'b1;
            2'd2:    r_jmp_req  <= 1'b1;
            default: r_st_req   <= 1'b1;
          endcase
          r_wdog  <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_finish) begin
            r_ins_req          <= 1'b0;
            r_data_req         <= 1'b0;
            r_jmp_req          <= 1'b0;
            r_st_req           <= 1'b0;
            r_done[r_rr_ptr]   <= 1'b1;
            r_cd               <= CW'(COOLDOWN_CYCLES);
            r_state            <= S_COOLDOWN;
          end else if (r_wdog >= TW'(TIMEOUT_CYCLES - 1)) begin
            r_ins_req  <= 1'b0;
            r_data_req <= 1'b0;
            r_jmp_req  <= 1'b0;
            r_st_req   <= 1'b0;
            r_err      <= 1'b1;
            r_cd       <= CW'(COOLDOWN_CYCLES);
            r_state    <= S_COOLDOWN;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (r_cd <= CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cd <= r_cd - 1'b1;
          end
        end
        default: begin
          r_state <= S_INIT_WAIT;
        end
      endcase
    end
  end

  assign grant_ack         = r_grant;
  assign done              = r_done;
  assign err_timeout       = r_err;
  assign busy              = r_busy;
  assign ins_read_req      = r_ins_req;
  assign ins_read_addr     = r_ins_addr;
  assign ins_read_len      = r_ins_len;
  assign data_read_req     = r_data_req;
  assign jmp_addr_read_req = r_jmp_req;
  assign data_read_addr    = r_rd_addr;
  assign data_store_req    = r_st_req;
  assign data_write_addr   = r_wr_addr;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: table-driven single transactions plus hand sequences
// for init blocking, round-robin fairness, watchdog and mid-burst reset.
// Grants and completions are checked against a scoreboard queue.
module tb_ddr_req_arbiter;

  localparam int AW = 28;
  localparam int LW = 8;
  localparam int CD = 3;
  localparam int TO = 32;

  logic          mem_clk = 1'b0;
  logic          rst_n;
  logic          ddr_init_input_finish;
  logic          ic_req, dc_rd_req, jmp_req, st_req;
  logic [AW-1:0] ic_addr, dc_rd_addr, jmp_addr, st_addr;
  logic [LW-1:0] ic_len;
  logic [3:0]    grant_ack, done;
  logic          err_timeout, busy;
  logic          ins_read_req, data_read_req, jmp_addr_read_req, data_store_req;
  logic [AW-1:0] ins_read_addr, data_read_addr, data_write_addr;
  logic [LW-1:0] ins_read_len;
  logic          rd_burst_finish, wr_burst_finish;

  ddr_req_arbiter #(
    .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .COOLDOWN_CYCLES(CD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .ddr_init_input_finish(ddr_init_input_finish),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .jmp_req(jmp_req), .jmp_addr(jmp_addr),
    .st_req(st_req), .st_addr(st_addr),
    .grant_ack(grant_ack), .done(done), .err_timeout(err_timeout),
    .ins_read_req(ins_read_req), .ins_read_addr(ins_read_addr), .ins_read_len(ins_read_len),
    .data_read_req(data_read_req), .jmp_addr_read_req(jmp_addr_read_req),
    .data_read_addr(data_read_addr), .data_store_req(data_store_req),
    .data_write_addr(data_write_addr),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
    .busy(busy)
  );

  // Free-running memory clock, rising edges at 5, 15, 25 ...
  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic [1:0]    who;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            lat;
    bit            wrong_first;
    bit            drop_early;
  } vec_t;

  typedef struct {
    logic [3:0]    g;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
  } gexp_t;

  typedef struct {
    logic [3:0] d;
    logic       e;
  } dexp_t;

  gexp_t         gq[$];
  dexp_t         dq[$];
  vec_t          vecs[6];
  logic [AW-1:0] tbAddr[4];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dnVec();
    return {data_store_req, jmp_addr_read_req, data_read_req, ins_read_req};
  endfunction

  // Compares each observed grant / completion against the scoreboard.
  task automatic checkOutput();
    gexp_t g;
    dexp_t d;
    chk("onehot_dn", 64'($countones(dnVec()) <= 1), 64'(1));
    if (grant_ack != 4'b0000) begin
      if (gq.size() == 0) chk("unexpected_grant", 64'(grant_ack), 64'(0));
      else begin
        g = gq.pop_front();
        chk("grant", 64'(grant_ack), 64'(g.g));
        if (g.g == 4'b0001) begin
          chk("ic_addr", 64'(ins_read_addr), 64'(g.a));
          chk("ic_len", 64'(ins_read_len), 64'(g.l));
        end else if (g.g == 4'b1000) chk("st_addr", 64'(data_write_addr), 64'(g.a));
        else chk("rd_addr", 64'(data_read_addr), 64'(g.a));
      end
    end
    if (done != 4'b0000 || err_timeout) begin
      if (dq.size() == 0) chk("unexpected_done", 64'({done, err_timeout}), 64'(0));
      else begin
        d = dq.pop_front();
        chk("done_err", 64'({done, err_timeout}), 64'({d.d, d.e}));
      end
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    @(negedge mem_clk);
    checkOutput();
  endtask

  task automatic driveReq(input logic [1:0] who, input logic val);
    case (who)
      2'd0: begin ic_req = val;    ic_addr = tbAddr[0];    end
      2'd1: begin dc_rd_req = val; dc_rd_addr = tbAddr[1]; end
      2'd2: begin jmp_req = val;   jmp_addr = tbAddr[2];   end
      default: begin st_req = val; st_addr = tbAddr[3];    end
    endcase
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_ctl"}, 64'({grant_ack, done, err_timeout, busy, dnVec()}), 64'(0));
    chk({tag, "_icaddr"}, 64'({ins_read_addr, ins_read_len}), 64'(0));
    chk({tag, "_rdwr"}, 64'({data_read_addr, data_write_addr}), 64'(0));
  endtask

  // One full transaction for requester 'who'; lat<0 means never finish.
  task automatic applyStimulus(input logic [1:0] who, input int lat, input bit wrongFirst,
                               input bit dropEarly, input bit keep);
    gexp_t g;
    dexp_t d;
    int    n;
    logic [3:0] oh;
    oh  = 4'b0001 << who;
    g.g = oh; g.a = tbAddr[who]; g.l = ic_len;
    gq.push_back(g);
    driveReq(who, 1'b1);
    n = 0;
    do begin tick(); n++; end while (grant_ack == 4'b0000 && n < 100);
    chk("grant_seen", 64'(n < 100), 64'(1));
    if (dropEarly) driveReq(who, 1'b0);
    tick();
    chk("dn_req", 64'(dnVec()), 64'(oh));
    if (lat < 0) begin
      d.d = 4'b0000; d.e = 1'b1;
      dq.push_back(d);
      n = 0;
      while (dnVec() != 4'b0000 && n < TO + 8) begin n++; tick(); end
      chk("timeout_len", 64'(n), 64'(TO));
    end else begin
      for (int c = 1; c < lat; c++) begin
        if (wrongFirst && c == 2) begin
          if (who == 2'd3) rd_burst_finish = 1'b1;
          else wr_burst_finish = 1'b1;
        end
        tick();
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
        if (wrongFirst && c == 2) chk("wrong_finish_ignored", 64'(dnVec()), 64'(oh));
      end
      if (who == 2'd3) wr_burst_finish = 1'b1;
      else rd_burst_finish = 1'b1;
      d.d = oh; d.e = 1'b0;
      dq.push_back(d);
      tick();
      rd_burst_finish = 1'b0;
      wr_burst_finish = 1'b0;
      chk("dn_drop", 64'(dnVec()), 64'(0));
    end
    if (!keep) begin
      driveReq(who, 1'b0);
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk("busy_clear", 64'(busy), 64'(0));
    end
  endtask

  // All four requesters held; grants must rotate starting at 'first'.
  task automatic holdAll(input logic [1:0] first, input int count);
    int n;
    for (int i = 0; i < 4; i++) driveReq(2'(i), 1'b1);
    for (int k = 0; k < count; k++) applyStimulus(first + 2'(k), 4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) driveReq(2'(i), 1'b0);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("holdall_idle", 64'(busy), 64'(0));
  endtask

  // Hard stop in case something upstream fails to terminate.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int    n;
    gexp_t g;
    dexp_t d;

    vecs[0] = '{who: 2'd1, addr: 28'h0001000, len: 8'd16,  lat: 5,  wrong_first: 1'b0, drop_early: 1'b0};
    vecs[1] = '{who: 2'd2, addr: 28'h0002340, len: 8'd16,  lat: 8,  wrong_first: 1'b0, drop_early: 1'b1};
    vecs[2] = '{who: 2'd3, addr: 28'h0ABCDE0, len: 8'd16,  lat: 6,  wrong_first: 1'b1, drop_early: 1'b0};
    vecs[3] = '{who: 2'd0, addr: 28'hFFFFFC0, len: 8'hFF,  lat: 1,  wrong_first: 1'b0, drop_early: 1'b0};
    vecs[4] = '{who: 2'd1, addr: 28'h0000000, len: 8'hFF,  lat: TO, wrong_first: 1'b0, drop_early: 1'b0};
    vecs[5] = '{who: 2'd1, addr: 28'h0123450, len: 8'hFF,  lat: -1, wrong_first: 1'b0, drop_early: 1'b0};

    rst_n = 1'b0; ddr_init_input_finish = 1'b0;
    ic_req = 0; dc_rd_req = 0; jmp_req = 0; st_req = 0;
    ic_addr = '0; dc_rd_addr = '0; jmp_addr = '0; st_addr = '0; ic_len = '0;
    rd_burst_finish = 0; wr_burst_finish = 0;
    for (int i = 0; i < 4; i++) tbAddr[i] = '0;

    tick(); tick();
    checkAllZero("reset");
    rst_n = 1'b1;

    tbAddr[0] = 28'h0000040; ic_len = 8'd16;
    tbAddr[3] = 28'h0000F00;
    driveReq(2'd0, 1'b1);
    n = 0;
    repeat (50) begin
      tick();
      if (grant_ack != 4'b0000 || dnVec() != 4'b0000) n++;
    end
    chk("init_block", 64'(n), 64'(0));
    chk("init_busy", 64'(busy), 64'(1));

    ddr_init_input_finish = 1'b1;
    g.g = 4'b0001; g.a = 28'h0000040; g.l = 8'd16;
    gq.push_back(g);
    tick();
    chk("grant_edge1", 64'(grant_ack), 64'(0));
    tick();
    chk("grant_edge2", 64'(grant_ack), 64'(4'b0001));
    tick();
    chk("ins_req_up", 64'(dnVec()), 64'(4'b0001));
    repeat (19) tick();
    chk("ins_req_hold", 64'(dnVec()), 64'(4'b0001));
    rd_burst_finish = 1'b1;
    d.d = 4'b0001; d.e = 1'b0;
    dq.push_back(d);
    tick();
    rd_burst_finish = 1'b0;
    driveReq(2'd0, 1'b0);
    chk("ins_req_drop", 64'(dnVec()), 64'(0));
    driveReq(2'd3, 1'b1);
    tick();
    chk("cool_busy1", 64'(busy), 64'(1));
    driveReq(2'd3, 1'b0);
    tick();
    chk("cool_busy2", 64'(busy), 64'(1));
    tick();
    chk("cool_busy3", 64'(busy), 64'(0));
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      tbAddr[vecs[i].who] = vecs[i].addr;
      ic_len = vecs[i].len;
      applyStimulus(vecs[i].who, vecs[i].lat, vecs[i].wrong_first, vecs[i].drop_early, 1'b0);
    end

    tbAddr[0] = 28'h0000100; tbAddr[1] = 28'h0000200;
    tbAddr[2] = 28'h0000300; tbAddr[3] = 28'h0000400; ic_len = 8'd4;
    holdAll(2'd2, 5);

    tbAddr[2] = 28'h0DEAD00;
    g.g = 4'b0100; g.a = tbAddr[2]; g.l = ic_len;
    gq.push_back(g);
    driveReq(2'd2, 1'b1);
    n = 0;
    do begin tick(); n++; end while (grant_ack == 4'b0000 && n < 100);
    chk("jmp_grant_seen", 64'(n < 100), 64'(1));
    tick();
    chk("jmp_req_up", 64'(dnVec()), 64'(4'b0100));
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    ddr_init_input_finish = 1'b0;
    #1;
    checkAllZero("midrst");
    driveReq(2'd2, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) driveReq(2'(i), 1'b1);
    repeat (10) tick();
    chk("reinit_busy", 64'(busy), 64'(1));
    chk("reinit_nodn", 64'(dnVec()), 64'(0));
    ddr_init_input_finish = 1'b1;
    holdAll(2'd0, 5);

    chk("sb_grant_empty", 64'(gq.size()), 64'(0));
    chk("sb_done_empty", 64'(dq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_req_arbiter.md
Name: ddr_req_arbiter

Overview:
- Sits between the instruction cache, the data cache and the DDR cache interface.
- Shares the single DDR command path between four requesters: instruction read, data read, jump-address read and data store.
- Grants one requester at a time using round-robin, presents exactly one request level to the DDR cache interface, and waits for the burst to finish.
- Enforces a post-burst cooldown and a watchdog timeout, and blocks all traffic until DDR initial loading is complete.

Parameters:
DDR_ADDR_WIDTH, 28, width of all DDR addresses
LEN_WIDTH, 8, width of instruction read length
COOLDOWN_CYCLES, 3, idle cycles after burst finish before the next grant (min 1)
TIMEOUT_CYCLES, 1024, cycles in WAIT_DONE before abort (min 2)

Ports:
mem_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ddr_init_input_finish  in  1  DDR preload complete; level, stays high
ic_req  in  1  instruction read request, level
ic_addr  in  DDR_ADDR_WIDTH  instruction read address
ic_len  in  LEN_WIDTH  instruction read length
dc_rd_req  in  1  data read request, level
dc_rd_addr  in  DDR_ADDR_WIDTH  data read address
jmp_req  in  1  jump-address read request, level
jmp_addr  in  DDR_ADDR_WIDTH  jump-address location
st_req  in  1  data store request, level
st_addr  in  DDR_ADDR_WIDTH  store address
grant_ack  out  4  one-cycle grant pulse per requester {st,jmp,dc_rd,ic}
done  out  4  one-cycle completion pulse per requester {st,jmp,dc_rd,ic}
err_timeout  out  1  one-cycle pulse on watchdog abort
ins_read_req  out  1  to DDR interface
ins_read_addr  out  DDR_ADDR_WIDTH  to DDR interface
ins_read_len  out  LEN_WIDTH  to DDR interface
data_read_req  out  1  to DDR interface
jmp_addr_read_req  out  1  to DDR interface
data_read_addr  out  DDR_ADDR_WIDTH  shared by data and jump reads
data_store_req  out  1  to DDR interface
data_write_addr  out  DDR_ADDR_WIDTH  to DDR interface
rd_burst_finish  in  1  from DDR controller, one-cycle pulse
wr_burst_finish  in  1  from DDR controller, one-cycle pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state INIT_WAIT, rr_ptr=3 so the first search starts at ic, counters 0. Reset is asynchronous at any point, including mid-burst; outstanding requests are dropped with no done pulse.
- INIT_WAIT: stays until ddr_init_input_finish=1, then goes to IDLE. Requests are ignored here; finish pulses are ignored here.
- IDLE:
  - Search order is (rr_ptr+1) mod 4 through +4, using index 0=ic, 1=dc_rd, 2=jmp, 3=st.
  - The first asserted request wins. The same edge latches its address (and len for ic) into output registers, sets rr_ptr=winner, pulses grant_ack[winner] and moves to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE:
  - Asserts exactly one downstream request level, chosen by winner: ins_read_req, data_read_req, jmp_addr_read_req or data_store_req.
  - Moves to WAIT_DONE on the next edge. Latched addresses stay stable until the next grant.
- WAIT_DONE:
  - Downstream request stays high.
  - Read winners (ic, dc_rd, jmp) complete on rd_burst_finish; st completes on wr_burst_finish. The opposite-type finish pulse is ignored.
  - On completion: request drops, done[winner] pulses the same edge, cooldown counter loads COOLDOWN_CYCLES, state goes to COOLDOWN.
  - A watchdog counts cycles in WAIT_DONE. When it reaches TIMEOUT_CYCLES: request drops, err_timeout pulses, no done pulse, state goes to COOLDOWN.
  - Finish and timeout on the same cycle: finish wins, no err_timeout.
- COOLDOWN: decrements each cycle; at 1 goes to IDLE. This gives the DDR interface time to return to its START state.
- Requester rules:
  - A requester holds req until its done pulse. Lowering req after the grant does not cancel the burst.
  - Lowering req before the grant withdraws it with no pulse.
  - A requester still asserting req after done competes again, but rr order places it last.
- Invariants: at most one downstream request high at any time; grant_ack and done are each at most one-hot.
- Counters saturate and never wrap. The latency from request to downstream request high is 2 edges when idle and not blocked.

Test Plan:
- Hold ddr_init_input_finish=0, assert ic_req -> no grant_ack or downstream request for 50 cycles. Raise init -> grant_ack=4'b0001 two edges later, then ins_read_req=1.
- ic_req with ic_addr=28'h0000040, ic_len=8'd16, rd_burst_finish pulsed 20 cycles after ins_read_req rises -> ins_read_addr=28'h0000040 and len 16; done=4'b0001 on the finish edge; busy low 3 cycles later.
- All four requests held continuously -> grants in order ic, dc_rd, jmp, st, ic. Never two downstream requests high together.
- st_req active, rd_burst_finish pulsed during WAIT_DONE -> ignored; completes only on a later wr_burst_finish, with data_write_addr=st_addr.
- dc_rd granted with no finish, TIMEOUT_CYCLES=16 -> data_read_req drops after 16 WAIT_DONE cycles, err_timeout pulses once, done stays 0, next grant goes to jmp.
- rst_n asserted mid-WAIT_DONE for jmp -> all outputs 0 immediately. After release the block waits in INIT_WAIT for ddr_init_input_finish high, then the first grant goes to ic.
